// File: rtl/acc_requant_8_pkg.sv
// Shared widths, saturation limits and helpers for the accumulate-and-requantize
// stage that sits after the saturating adder tree.
package acc_requant_8_pkg;

  localparam int IN_W    = 18;
  localparam int ACC_W   = 18;
  localparam int OUT_W   = 8;
  localparam int SHIFT_W = 4;
  localparam int CNT_W   = 8;

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic signed [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

  // One finished output pixel as it sits in the output register.
  typedef struct packed {
    logic signed [OUT_W-1:0] data;
    logic                    sat;
    logic [CNT_W-1:0]        count;
  } result_t;

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

endpackage

// File: rtl/acc_requant_8_round_clip.sv
// Round-half-up, arithmetic right shift, optional ReLU and clip of a
// saturated accumulator value down to a signed activation.
module requant_round_clip
  import acc_requant_8_pkg::*;
(
  input  logic signed [ACC_W-1:0]   i_sum,
  input  logic        [SHIFT_W-1:0] i_shift,
  input  logic                      i_relu,
  output logic signed [OUT_W-1:0]   o_q,
  output logic                      o_clip
);

  localparam int RW = ACC_W + 1;

  logic signed [RW-1:0] w_round;
  logic signed [RW-1:0] w_rounded;
  logic signed [RW-1:0] w_shifted;
  logic signed [RW-1:0] w_relu;
  logic [RW-OUT_W:0]    w_hi;

  always_comb begin
    w_round = '0;
    if (i_shift != '0) begin
      w_round = RW'(1) << (i_shift - 1'b1);
    end
    w_rounded = RW'(i_sum) + w_round;
    w_shifted = w_rounded >>> i_shift;

    w_relu = w_shifted;
    if (i_relu && w_shifted[RW-1]) begin
      w_relu = '0;
    end

    // In range only when every bit above the output sign bit matches it.
    w_hi   = w_relu[RW-1:OUT_W-1];
    o_clip = !((&w_hi) || !(|w_hi));
    o_q    = w_relu[OUT_W-1:0];
    if (o_clip) begin
      o_q = w_relu[RW-1] ? OUT_MIN : OUT_MAX;
    end
  end

endmodule

// File: rtl/acc_requant_8.sv
// Accumulates a group of saturated partial sums per output pixel and emits one
// requantized signed 8-bit activation per group over a valid/ready handshake.
module acc_requant_8
  import acc_requant_8_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [IN_W-1:0]    in_data,
  input  logic                      in_last,
  input  logic        [SHIFT_W-1:0] cfg_shift,
  input  logic                      cfg_relu,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [OUT_W-1:0]   out_data,
  output logic                      out_sat,
  output logic        [CNT_W-1:0]   out_count
);

  logic signed [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0]        r_count;
  logic                    r_sat;
  logic                    r_outValid;
  result_t                 r_res;

  logic                    w_accept;
  logic signed [ACC_W:0]   w_sum;
  logic                    w_ovfPos;
  logic                    w_ovfNeg;
  logic                    w_ovf;
  logic signed [ACC_W-1:0] w_sumSat;
  logic [CNT_W-1:0]        w_cntNext;
  logic signed [OUT_W-1:0] w_q;
  logic                    w_clip;

  assign in_ready  = !r_outValid || out_ready;
  assign w_accept  = in_valid && in_ready;

  assign w_sum     = (ACC_W+1)'(r_acc) + (ACC_W+1)'(in_data);
  assign w_ovfPos  = (w_sum[ACC_W:ACC_W-1] == 2'b01);
  assign w_ovfNeg  = (w_sum[ACC_W:ACC_W-1] == 2'b10);
  assign w_ovf     = w_ovfPos || w_ovfNeg;
  assign w_sumSat  = w_ovfPos ? ACC_MAX : (w_ovfNeg ? ACC_MIN : w_sum[ACC_W-1:0]);
  assign w_cntNext = satInc(r_count);

  requant_round_clip u_requant (
    .i_sum   (w_sumSat),
    .i_shift (cfg_shift),
    .i_relu  (cfg_relu),
    .o_q     (w_q),
    .o_clip  (w_clip)
  );

  // The last beat of a group leaves the running state clean for the next group.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc   <= '0;
      r_count <= '0;
      r_sat   <= 1'b0;
    end else if (w_accept) begin
      if (in_last) begin
        r_acc   <= '0;
        r_count <= '0;
        r_sat   <= 1'b0;
      end else begin
        r_acc   <= w_sumSat;
        r_count <= w_cntNext;
        r_sat   <= r_sat || w_ovf;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_outValid <= 1'b0;
      r_res      <= '0;
    end else if (w_accept && in_last) begin
      r_outValid  <= 1'b1;
      r_res.data  <= w_q;
      r_res.sat   <= r_sat || w_ovf || w_clip;
      r_res.count <= w_cntNext;
    end else if (out_ready) begin
      r_outValid <= 1'b0;
    end
  end

  assign out_valid = r_outValid;
  assign out_data  = r_res.data;
  assign out_sat   = r_res.sat;
  assign out_count = r_res.count;

endmodule

// File: tb/tb_acc_requant_8.sv
// Self-checking bench for acc_requant_8: directed literal cases plus a
// randomized run, all compared every cycle against an integer reference model.
module tb_acc_requant_8;
  import acc_requant_8_pkg::*;

  logic                      clk = 1'b0;
  logic                      reset;
  logic                      in_valid;
  logic                      in_ready;
  logic signed [IN_W-1:0]    in_data;
  logic                      in_last;
  logic        [SHIFT_W-1:0] cfg_shift;
  logic                      cfg_relu;
  logic                      out_valid;
  logic                      out_ready;
  logic signed [OUT_W-1:0]   out_data;
  logic                      out_sat;
  logic        [CNT_W-1:0]   out_count;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state: running group plus the pending result.
  int mAcc;
  int mCnt;
  bit mSat;
  bit mValid;
  int mData;
  bit mOutSat;
  int mCount;

  always #5 clk = ~clk;

  acc_requant_8 dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .cfg_shift (cfg_shift),
    .cfg_relu  (cfg_relu),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .out_count (out_count)
  );

  task automatic checkValue(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic int requantModel(input int s, input int sh, input bit relu, output bit clip);
    int r;
    int q;
    r = s + ((sh > 0) ? (1 << (sh - 1)) : 0);
    q = r >>> sh;
    if (relu && q < 0) q = 0;
    clip = 1'b0;
    if (q > 127) begin q = 127; clip = 1'b1; end
    else if (q < -128) begin q = -128; clip = 1'b1; end
    return q;
  endfunction

  task automatic modelReset();
    mAcc = 0; mCnt = 0; mSat = 0;
    mValid = 0; mData = 0; mOutSat = 0; mCount = 0;
  endtask

  // Compare the DUT against the model, then advance the model across the next edge.
  task automatic checkCycle();
    bit expReady;
    bit accepted;
    bit ovf;
    bit clip;
    int s;
    int cnt;
    if (reset) modelReset();
    expReady = !mValid || out_ready;
    checkValue("in_ready", int'(in_ready), int'(expReady));
    checkValue("out_valid", int'(out_valid), int'(mValid));
    if (mValid || reset) begin
      checkValue("out_data", int'(out_data), mData);
      checkValue("out_sat", int'(out_sat), int'(mOutSat));
      checkValue("out_count", int'(out_count), mCount);
    end
    if (reset) return;
    accepted = in_valid && expReady;
    if (accepted) begin
      s = mAcc + int'(in_data);
      ovf = 1'b0;
      if (s > 131071) begin s = 131071; ovf = 1'b1; end
      else if (s < -131072) begin s = -131072; ovf = 1'b1; end
      cnt = (mCnt < 255) ? mCnt + 1 : 255;
      if (in_last) begin
        mData   = requantModel(s, int'(cfg_shift), cfg_relu, clip);
        mOutSat = mSat || ovf || clip;
        mCount  = cnt;
        mValid  = 1'b1;
        mAcc = 0; mCnt = 0; mSat = 0;
      end else begin
        mAcc = s; mCnt = cnt; mSat = mSat || ovf;
        if (mValid && out_ready) mValid = 1'b0;
      end
    end else if (mValid && out_ready) begin
      mValid = 1'b0;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    checkCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input bit v, input int d, input bit last, input int sh, input bit relu);
    in_valid  = v;
    in_data   = IN_W'(d);
    in_last   = last;
    cfg_shift = SHIFT_W'(sh);
    cfg_relu  = relu;
    tick();
  endtask

  task automatic checkOutput(input string tag, input int data, input bit sat, input int count);
    checkValue({tag, ".out_valid"}, int'(out_valid), 1);
    checkValue({tag, ".out_data"}, int'(out_data), data);
    checkValue({tag, ".out_sat"}, int'(out_sat), int'(sat));
    checkValue({tag, ".out_count"}, int'(out_count), count);
  endtask

  initial begin
    modelReset();
    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    cfg_shift = '0; cfg_relu = 1'b0; out_ready = 1'b1;
    tick();
    tick();
    checkValue("reset.out_valid", int'(out_valid), 0);
    checkValue("reset.out_data", int'(out_data), 0);
    checkValue("reset.out_count", int'(out_count), 0);
    reset = 1'b0;
    applyStimulus(0, 0, 0, 0, 0);

    applyStimulus(1, 10, 0, 0, 0);
    applyStimulus(1, 20, 0, 0, 0);
    applyStimulus(1, 30, 1, 2, 0);
    checkOutput("basic", 15, 0, 3);

    applyStimulus(1, 131000, 0, 0, 0);
    applyStimulus(1, 1000, 1, 15, 0);
    checkOutput("accsat", 4, 1, 2);

    applyStimulus(1, -6, 1, 2, 0);
    checkOutput("neg", -1, 0, 1);
    applyStimulus(1, -6, 1, 2, 1);
    checkOutput("relu", 0, 0, 1);

    applyStimulus(1, -131072, 1, 0, 0);
    checkOutput("clipneg", -128, 1, 1);
    applyStimulus(1, 200, 1, 0, 0);
    checkOutput("clippos", 127, 1, 1);

    applyStimulus(0, 0, 0, 0, 0);
    out_ready = 1'b0;
    applyStimulus(1, 5, 1, 0, 0);
    checkOutput("stall.load", 5, 0, 1);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 99, 0, 0, 0);
      checkValue("stall.in_ready", int'(in_ready), 0);
      checkOutput("stall.hold", 5, 0, 1);
    end
    out_ready = 1'b1;
    applyStimulus(1, 3, 1, 0, 0);
    checkOutput("nobubble", 3, 0, 1);

    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(1, 50, 0, 0, 0);
    applyStimulus(1, 50, 0, 0, 0);
    reset = 1'b1; in_valid = 1'b0;
    tick();
    reset = 1'b0;
    applyStimulus(1, 7, 1, 0, 0);
    checkOutput("midreset", 7, 0, 1);

    for (int i = 0; i < 300; i++) applyStimulus(1, 1, 0, 0, 0);
    applyStimulus(1, 1, 1, 0, 0);
    checkOutput("cntsat", 127, 1, 255);

    for (int i = 0; i < 3000; i++) begin
      int d;
      case ($urandom_range(0, 3))
        0: d = int'($urandom_range(0, 400)) - 200;
        1: d = int'($urandom_range(0, 10000)) - 5000;
        2: d = int'($urandom_range(0, 80000)) - 40000;
        default: d = int'($urandom_range(0, 262143)) - 131072;
      endcase
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 499) == 0) begin
        reset = 1'b1; in_valid = 1'b0;
        tick();
        reset = 1'b0;
      end
      applyStimulus($urandom_range(0, 4) != 0, d, $urandom_range(0, 3) == 0,
                    int'($urandom_range(0, 15)), $urandom_range(0, 1) == 1);
    end

    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/acc_requant_8.md
Name: acc_requant_8

Overview:
Consumer end of the saturating adder tree. Takes a stream of 18-bit saturated partial sums and accumulates one output pixel's group of beats, with saturation. On the group's last beat it requantizes the sum (round, shift, optional ReLU, clip) to a signed 8-bit activation. Sits between the adder-tree output and the activation write-back buffer, with valid/ready handshakes on both sides.

Parameters:
IN_W, 18, input partial-sum width (signed)
ACC_W, 18, accumulator width (signed, saturating)
OUT_W, 8, output activation width (signed)
SHIFT_W, 4, width of cfg_shift (shift range 0..15)
CNT_W, 8, beat-counter width

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
in_valid  input  1  partial-sum beat valid
in_ready  output  1  block can accept a beat
in_data  input  IN_W  signed partial sum
in_last  input  1  final beat of the current group
cfg_shift  input  SHIFT_W  right-shift amount; sampled on the accepted last beat
cfg_relu  input  1  clamp negatives to 0; sampled on the accepted last beat
out_valid  output  1  requantized result valid
out_ready  input  1  downstream accepts the result
out_data  output  OUT_W  signed requantized activation
out_sat  output  1  saturation occurred in this group (accumulate or clip)
out_count  output  CNT_W  beats in the group; saturates at 2^CNT_W-1

Behaviour:
- Reset (asynchronous, active-high) clears acc, beat count and the sticky sat flag. Outputs reset to out_valid=0, out_data=0, out_sat=0, out_count=0. Reset mid-group discards the partial group.
- A beat is accepted when in_valid && in_ready.
- in_ready = !out_valid || out_ready. Input stalls only while a result is pending and not being taken.
- Accumulate on every accepted beat: sum = acc + in_data, computed in ACC_W+1 bits.
  - Sum top two bits 01: result = +131071 and set the sat flag.
  - Sum top two bits 10: result = -131072 and set the sat flag.
  - Otherwise take the low ACC_W bits.
- Non-last beat: acc and the sticky sat flag update; the count increments, saturating at its maximum.
- Last beat: the final sum includes this beat. acc, count and the sat flag clear on the same edge, so the next beat starts a fresh group.
- Requantization of the final sum s (combinational, registered into the output):
  - r = s + (shift>0 ? 1<<(shift-1) : 0), computed in ACC_W+1 bits.
  - q = r >>> shift (arithmetic shift).
  - If cfg_relu and q<0, q = 0.
  - Clip q to [-128, 127]; clipping sets out_sat.
- Latency: out_valid rises on the edge after the last beat is accepted (1 cycle).
- out_data, out_sat and out_count hold stable while out_valid && !out_ready.
- Result taken and a new last beat accepted in the same cycle: out_valid stays 1 and the registers load the new result, giving back-to-back output with no bubble.
- Result taken with no new last beat: out_valid falls to 0.
- Single-beat group (in_last on the first beat) is legal; count = 1.
- No FSM beyond two implicit states: ACC (out_valid=0) and HOLD (out_valid=1). Transitions are fully set by the rules above.

Decomposition:
- Shared package holds:
  - width constants (IN_W, ACC_W, OUT_W, SHIFT_W, CNT_W);
  - saturation limits ACC_MAX = 131071, ACC_MIN = -131072, OUT_MAX = 127, OUT_MIN = -128.
- One combinational sub-module, requant_round_clip, implements round/shift/ReLU/clip. It outputs q and a clip flag.
- The top level holds the accumulator, the counter and the output register/handshake.

Test Plan:
1. Beats 10, 20, 30 (last); shift=2, relu=0 -> out_data 15, out_sat 0, out_count 3, one cycle after the last beat.
2. Beats 131000, 1000 (last); shift=15 -> acc saturates to 131071; out_data 4, out_sat 1, out_count 2.
3. Single beat -6 (last); shift=2 -> out_data -1. Repeat with relu=1 -> out_data 0. out_sat 0 in both cases.
4. Single beat -131072 (last); shift=0 -> out_data -128, out_sat 1. Single beat 200, shift=0 -> out_data 127, out_sat 1.
5. Backpressure:
   - Hold out_ready=0 with a result pending -> in_ready 0; out_data stable for 5 cycles.
   - Raise out_ready in the same cycle as a new last beat 3 (shift 0) -> next cycle out_valid 1, out_data 3, no bubble.
6. Reset mid-group: beats 50, 50, then reset for 1 cycle, then beat 7 (last), shift 0 -> out_data 7, out_count 1, out_sat 0.
